entrada_placa: RTL and testbench

Board-input conditioner for the processor top level: the input-side counterpart of the 7-segment output path. It synchronizes and debounces the raw active-low KEY buttons and the SW switches on CLK_28. It produces the CPU step and reset levels, single-cycle press pulses, and the divided automatic clock that the top level selects between.

---
 rtl/entrada_placa_if.sv | 22 ++
 rtl/entrada_placa.sv | 142 ++++++++++++++
 tb/tb_entrada_placa.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/entrada_placa_if.sv
// Board-input bundle for entrada_placa: raw KEY/SW in, conditioned levels, pulses and clocks out.
interface entrada_placa_if;
   logic [3:0]  KEY;
   logic [17:0] SW;
   logic [17:0] sw_sync;
   logic [3:0]  key_level;
   logic [3:0]  key_press;
   logic        btRst;
   logic        btStep;
   logic        clk_auto;
   logic        tick_auto;

   modport slave (
      input  KEY, SW,
      output sw_sync, key_level, key_press, btRst, btStep, clk_auto, tick_auto
   );

   modport master (
      output KEY, SW,
      input  sw_sync, key_level, key_press, btRst, btStep, clk_auto, tick_auto
   );
endinterface

// File: rtl/entrada_placa.sv
// Board-input conditioner: synchronizes SW, debounces active-low KEY, divides CLK_28 into clk_auto.
// Optional ENTRADA_REPEAT_EN adds per-key auto-repeat of key_press while a key stays held.
module entrada_placa #(
   parameter int DEB_CYCLES    = 280000,
   parameter int AUTO_DIV      = 14000000,
   parameter int REPEAT_DELAY  = 14000000,
   parameter int REPEAT_PERIOD = 2800000
) (
   input  logic              CLK_28,
   input  logic              RST_N,
   entrada_placa_if.slave    bus
);
   localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam int DIV_W = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
   localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES - 1);
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(AUTO_DIV - 1);

   if (DEB_CYCLES < 1 || AUTO_DIV < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
      $error("entrada_placa: all cycle-count parameters must be >= 1");
   end

   logic [3:0]       r_key_p0, r_key_p1;
   logic [17:0]      r_sw_p0,  r_sw_p1;
   logic [3:0]       r_level, r_press;
   logic [DEB_W-1:0] r_cnt [4];
   logic [DIV_W-1:0] r_div;
   logic             r_clk_auto, r_tick;

   logic [3:0]       w_accept, w_level_nxt, w_press_nxt, w_rep_fire;
   logic [DEB_W-1:0] w_cnt_nxt [4];
   logic             w_wrap;

   // Stage p0/p1: two-flop synchronizers; keys are inverted first so 1 = pressed.
   always_ff @(posedge CLK_28 or negedge RST_N) begin
      if (!RST_N) begin
         r_key_p0 <= '0;
         r_key_p1 <= '0;
         r_sw_p0  <= '0;
         r_sw_p1  <= '0;
      end else begin
         r_key_p0 <= ~bus.KEY;
         r_key_p1 <= r_key_p0;
         r_sw_p0  <= bus.SW;
         r_sw_p1  <= r_sw_p0;
      end
   end

   always_comb begin
      w_accept    = '0;
      w_level_nxt = r_level;
      w_press_nxt = '0;
      for (int i = 0; i < 4; i++) begin
         w_cnt_nxt[i] = '0;
         if (r_key_p1[i] != r_level[i]) begin
            if (r_cnt[i] == DEB_MAX) begin
               w_accept[i]    = 1'b1;
               w_level_nxt[i] = r_key_p1[i];
            end else begin
               w_cnt_nxt[i] = r_cnt[i] + 1'b1;
            end
         end
         w_press_nxt[i] = (w_accept[i] & r_key_p1[i]) | w_rep_fire[i];
      end
   end

`ifdef ENTRADA_REPEAT_EN
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
   localparam logic [REP_W-1:0] DLY_MAX = REP_W'(REPEAT_DELAY - 1);
   localparam logic [REP_W-1:0] PER_MAX = REP_W'(REPEAT_PERIOD - 1);

   logic [REP_W-1:0] r_rep_cnt [4];
   logic [3:0]       r_rep_phase;
   logic [REP_W-1:0] w_rep_cnt_nxt [4];
   logic [3:0]       w_rep_phase_nxt;

   // Phase 0 waits out the initial delay, phase 1 runs the steady repeat period.
   always_comb begin
      w_rep_fire      = '0;
      w_rep_phase_nxt = '0;
      for (int i = 0; i < 4; i++) begin
         w_rep_cnt_nxt[i] = '0;
         if (r_level[i] && w_level_nxt[i]) begin
            if (r_rep_cnt[i] == (r_rep_phase[i] ? PER_MAX : DLY_MAX)) begin
               w_rep_fire[i]      = 1'b1;
               w_rep_phase_nxt[i] = 1'b1;
            end else begin
               w_rep_cnt_nxt[i]   = r_rep_cnt[i] + 1'b1;
               w_rep_phase_nxt[i] = r_rep_phase[i];
            end
         end
      end
   end

   always_ff @(posedge CLK_28 or negedge RST_N) begin
      if (!RST_N) begin
         r_rep_phase <= '0;
         for (int i = 0; i < 4; i++) r_rep_cnt[i] <= '0;
      end else begin
         r_rep_phase <= w_rep_phase_nxt;
         for (int i = 0; i < 4; i++) r_rep_cnt[i] <= w_rep_cnt_nxt[i];
      end
   end
`else
   assign w_rep_fire = '0;
`endif

   // Stage p2: debounced level and press pulse registers.
   always_ff @(posedge CLK_28 or negedge RST_N) begin
      if (!RST_N) begin
         r_level <= '0;
         r_press <= '0;
         for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
      end else begin
         r_level <= w_level_nxt;
         r_press <= w_press_nxt;
         for (int i = 0; i < 4; i++) r_cnt[i] <= w_cnt_nxt[i];
      end
   end

   assign w_wrap = (r_div == DIV_MAX);

   always_ff @(posedge CLK_28 or negedge RST_N) begin
      if (!RST_N) begin
         r_div      <= '0;
         r_clk_auto <= 1'b0;
         r_tick     <= 1'b0;
      end else begin
         r_div      <= w_wrap ? '0 : r_div + 1'b1;
         r_clk_auto <= r_clk_auto ^ w_wrap;
         r_tick     <= w_wrap & ~r_clk_auto;
      end
   end

   assign bus.sw_sync   = r_sw_p1;
   assign bus.key_level = r_level;
   assign bus.key_press = r_press;
   assign bus.btRst     = r_level[0];
   assign bus.btStep    = r_level[1];
   assign bus.clk_auto  = r_clk_auto;
   assign bus.tick_auto = r_tick;
endmodule

// File: tb/tb_entrada_placa.sv
// Bench for entrada_placa: directed board scenarios plus random key/switch traffic vs. a reference model.
module tb_entrada_placa;
   localparam int DEB  = 4;
   localparam int DIV  = 3;
   localparam int RDLY = 10;
   localparam int RPER = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   entrada_placa_if bus();

   entrada_placa #(
      .DEB_CYCLES(DEB), .AUTO_DIV(DIV), .REPEAT_DELAY(RDLY), .REPEAT_PERIOD(RPER)
   ) dut (
      .CLK_28(clk), .RST_N(rst_n), .bus(bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: delay lines for synchronizers, a sliding window of synced samples for debounce,
   // edge count since reset for the auto clock, and per-key hold age for presses/repeats.
   logic [3:0]  m_kq[$];
   logic [17:0] m_swq[$];
   logic [3:0]  m_win[$];
   logic [3:0]  m_lvl, m_press;
   int          m_age[4];
   int          m_k;

   function automatic void model_reset();
      m_kq  = '{4'h0, 4'h0};
      m_swq = '{18'h0, 18'h0};
      m_win.delete();
      m_lvl = '0;
      m_press = '0;
      m_k = 0;
      for (int i = 0; i < 4; i++) m_age[i] = 0;
   endfunction

   function automatic void model_edge(input logic [3:0] key, input logic [17:0] sw);
      logic [3:0] s;
      logic old, nl, flip;
      s = m_kq[0];
      void'(m_kq.pop_front());
      m_kq.push_back(~key);
      void'(m_swq.pop_front());
      m_swq.push_back(sw);
      m_win.push_back(s);
      if (m_win.size() > DEB) void'(m_win.pop_front());
      for (int i = 0; i < 4; i++) begin
         old  = m_lvl[i];
         flip = (m_win.size() == DEB);
         foreach (m_win[j]) if (m_win[j][i] == old) flip = 1'b0;
         nl = flip ? ~old : old;
         m_press[i] = 1'b0;
         if (nl) begin
            if (!old) begin
               m_age[i] = 0;
               m_press[i] = 1'b1;
            end else begin
               m_age[i]++;
`ifdef ENTRADA_REPEAT_EN
               if (m_age[i] >= RDLY && ((m_age[i] - RDLY) % RPER) == 0) m_press[i] = 1'b1;
`endif
            end
         end
         m_lvl[i] = nl;
      end
      m_k++;
   endfunction

   task automatic compare_all();
      chk("sw_sync",   bus.sw_sync,   m_swq[0]);
      chk("key_level", bus.key_level, m_lvl);
      chk("key_press", bus.key_press, m_press);
      chk("btRst",     bus.btRst,     m_lvl[0]);
      chk("btStep",    bus.btStep,    m_lvl[1]);
      chk("clk_auto",  bus.clk_auto,  ((m_k / DIV) % 2) == 1);
      chk("tick_auto", bus.tick_auto, (m_k > 0) && ((m_k % (2 * DIV)) == DIV));
   endtask

   // Called #1 after a rising edge; drives inputs, advances one edge, checks.
   task automatic cyc(input logic [3:0] key, input logic [17:0] sw);
      bus.KEY = key;
      bus.SW  = sw;
      @(posedge clk);
      model_edge(key, sw);
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      #1;
      compare_all();
      @(posedge clk);
      #1;
      compare_all();
      rst_n = 1'b1;
   endtask

   task automatic settle();
      repeat (10) cyc(4'hF, 18'($urandom));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int pulses;
      logic [3:0]  rk;
      logic [17:0] rsw;

      // Reset with all keys held down: outputs must stay at 0.
      bus.KEY = 4'h0;
      bus.SW  = 18'h3FFFF;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      compare_all();
      chk("rst_outputs", {bus.key_level, bus.key_press, bus.clk_auto, bus.tick_auto}, 10'h0);
      rst_n = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         cyc(4'hF, 18'h0);
         if (c == 3) chk("first_rise", {bus.clk_auto, bus.tick_auto}, 2'b11);
         if (c == 4) chk("tick_one_cycle", bus.tick_auto, 1'b0);
         if (c == 9) chk("second_tick", bus.tick_auto, 1'b1);
      end

      // Clean press and release of KEY[1].
      settle();
      n = 0;
      do begin cyc(4'b1101, 18'h0); n++; end while (!bus.btStep && n < 20);
      chk("step_press_lat", n, 6);
      chk("step_press_pulse", bus.key_press, 4'b0010);
      cyc(4'b1101, 18'h0);
      chk("step_pulse_end", bus.key_press, 4'b0000);
      n = 0;
      pulses = 0;
      do begin cyc(4'hF, 18'h0); n++; pulses += bus.key_press[1]; end while (bus.btStep && n < 20);
      chk("step_release_lat", n, 6);
      chk("step_release_nopulse", pulses, 0);

      // Bounce on KEY[0] then a steady hold.
      settle();
      for (int c = 0; c < 20; c++) begin
         cyc({3'b111, (c % 3) != 2}, 18'h0);
         chk("bounce_rst_low", bus.btRst, 1'b0);
      end
      n = 0;
      do begin cyc(4'b1110, 18'h0); n++; end while (!bus.btRst && n < 20);
      chk("bounce_hold_lat", n, 6);

      // Simultaneous press of KEY[3:2].
      settle();
      n = 0;
      do begin cyc(4'b0011, 18'h0); n++; end while (bus.key_press == 4'h0 && n < 20);
      chk("simul_press", bus.key_press, 4'b1100);
      settle();

      // Reset mid-debounce on KEY[0].
      repeat (3) cyc(4'b1110, 18'h0);
      do_reset();
      n = 0;
      do begin cyc(4'b1110, 18'h0); n++; end while (!bus.btRst && n < 20);
      chk("rst_mid_lat", n, 6);

      // Long hold of KEY[2]: repeat pulses only when the option is built in.
      settle();
      pulses = 0;
      for (int c = 0; c < 30; c++) begin
         cyc(4'b1011, 18'h0);
         pulses += bus.key_press[2];
      end
`ifdef ENTRADA_REPEAT_EN
      chk("hold_pulses", pulses, 4);
`else
      chk("hold_pulses", pulses, 1);
`endif
      settle();

      // Random traffic with occasional resets.
      rk  = 4'hF;
      rsw = 18'h0;
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < 4; i++) if ($urandom_range(0, 9) == 0) rk[i] = ~rk[i];
         if ($urandom_range(0, 3) == 0) rsw = 18'($urandom);
         if ($urandom_range(0, 299) == 0) begin
            bus.KEY = rk;
            do_reset();
         end else begin
            cyc(rk, rsw);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
